// File: rtl/dev_uart8.sv
// Memory-mapped 8N1 UART: bus slave with DATA/STATUS/BAUD/CTRL registers,
// TX/RX FIFOs, 2-flop RX synchronizer and level interrupt requests.
module dev_uart8 #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  output logic        ack,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [31:0] dwrite,
  output logic [31:0] dtr,
  input  logic        rx,
  output logic        tx,
  output logic        irq_rx,
  output logic        irq_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Configuration, flags and bus outputs
  logic [15:0] r_baud;
  logic [1:0]  r_ctrl;
  logic        r_ovr, r_ferr;
  logic        r_irq_rx, r_irq_tx;
  logic        r_ack;
  logic [31:0] r_dtr;

  // TX FIFO
  logic [7:0]  r_txf_mem [FIFO_DEPTH];
  logic [AW:0] r_txf_wp, r_txf_rp;
  logic        w_txf_empty, w_txf_full, w_txf_push, w_txf_pop;
  logic [7:0]  w_txf_head;

  // RX FIFO
  logic [7:0]  r_rxf_mem [FIFO_DEPTH];
  logic [AW:0] r_rxf_wp, r_rxf_rp;
  logic        w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;
  logic [7:0]  w_rxf_head;

  // TX FSM
  state_e      r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx;

  // RX synchronizer and FSM
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  state_e      r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;

  // Bus decode and derived status
  logic        w_rd_data, w_wr_data, w_rd_status, w_wr_baud, w_wr_ctrl;
  logic        w_tx_empty, w_tx_busy;
  logic        w_rx_done, w_rx_push_req, w_ovr_set, w_ferr_set;
  logic [5:0]  w_status;
  logic [31:0] w_rdata;
  logic [16:0] w_half;
  logic [15:0] w_half_m1;
  logic        w_unused_dwrite;

  assign w_unused_dwrite = ^dwrite[31:16];

  assign w_rd_data   = stb & ~rw & (addr == 3'd0);
  assign w_wr_data   = stb &  rw & (addr == 3'd0);
  assign w_rd_status = stb & ~rw & (addr == 3'd1);
  assign w_wr_baud   = stb &  rw & (addr == 3'd2);
  assign w_wr_ctrl   = stb &  rw & (addr == 3'd3);

  assign w_txf_empty = (r_txf_wp == r_txf_rp);
  assign w_txf_full  = (r_txf_wp[AW] != r_txf_rp[AW]) &&
                       (r_txf_wp[AW-1:0] == r_txf_rp[AW-1:0]);
  assign w_txf_head  = r_txf_mem[r_txf_rp[AW-1:0]];
  assign w_rxf_empty = (r_rxf_wp == r_rxf_rp);
  assign w_rxf_full  = (r_rxf_wp[AW] != r_rxf_rp[AW]) &&
                       (r_rxf_wp[AW-1:0] == r_rxf_rp[AW-1:0]);
  assign w_rxf_head  = r_rxf_mem[r_rxf_rp[AW-1:0]];

  // TX pops when a frame starts, either from idle or back-to-back after a stop bit
  assign w_txf_pop  = ~w_txf_empty &
                      ((r_tx_state == StIdle) || ((r_tx_state == StStop) && (r_tx_cnt == 16'd0)));
  assign w_txf_push = w_wr_data & (~w_txf_full | w_txf_pop);

  assign w_rx_done     = (r_rx_state == StStop) && (r_rx_cnt == 16'd0);
  assign w_rx_push_req = w_rx_done & r_rx_s2;
  assign w_ferr_set    = w_rx_done & ~r_rx_s2;
  assign w_rxf_pop     = w_rd_data & ~w_rxf_empty;
  assign w_rxf_push    = w_rx_push_req & (~w_rxf_full | w_rxf_pop);
  assign w_ovr_set     = w_rx_push_req & w_rxf_full & ~w_rxf_pop;

  assign w_tx_busy  = (r_tx_state != StIdle);
  assign w_tx_empty = w_txf_empty & ~w_tx_busy;
  assign w_status   = {r_ferr, r_ovr, w_tx_busy, w_tx_empty, w_txf_full, ~w_rxf_empty};

  assign w_half    = ({1'b0, r_baud} + 17'd1) >> 1;
  assign w_half_m1 = (w_half == 17'd0) ? 16'd0 : w_half[15:0] - 16'd1;

  always_comb begin
    w_rdata = '0;
    case (addr)
      3'd0:    w_rdata = w_rxf_empty ? 32'd0 : {24'd0, w_rxf_head};
      3'd1:    w_rdata = {26'd0, w_status};
      3'd2:    w_rdata = {16'd0, r_baud};
      3'd3:    w_rdata = {30'd0, r_ctrl};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dtr <= '0;
    end else begin
      r_ack <= stb;
      r_dtr <= (stb && !rw) ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud   <= DEFAULT_DIV[15:0];
      r_ctrl   <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      r_irq_rx <= 1'b0;
      r_irq_tx <= 1'b0;
    end else begin
      if (w_wr_baud) r_baud <= dwrite[15:0];
      if (w_wr_ctrl) r_ctrl <= dwrite[1:0];
      // A same-cycle event wins over the clearing STATUS read
      r_ovr    <= w_ovr_set  | (r_ovr  & ~w_rd_status);
      r_ferr   <= w_ferr_set | (r_ferr & ~w_rd_status);
      r_irq_rx <= r_ctrl[0] & ~w_rxf_empty;
      r_irq_tx <= r_ctrl[1] & w_tx_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txf_wp <= '0;
      r_txf_rp <= '0;
      r_rxf_wp <= '0;
      r_rxf_rp <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_txf_pop)  r_txf_rp <= r_txf_rp + 1'b1;
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
      if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wp[AW-1:0]] <= dwrite[7:0];
    if (w_rxf_push) r_rxf_mem[r_rxf_wp[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= StIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        StIdle: begin
          if (!w_txf_empty) begin
            r_tx_state <= StStart;
            r_tx_cnt   <= r_baud;
            r_tx_shift <= w_txf_head;
            r_tx       <= 1'b0;
          end
        end
        StStart: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= StData;
            r_tx_cnt   <= r_baud;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        StData: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= r_baud;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= StStop;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        StStop: begin
          if (r_tx_cnt == 16'd0) begin
            if (!w_txf_empty) begin
              r_tx_state <= StStart;
              r_tx_cnt   <= r_baud;
              r_tx_shift <= w_txf_head;
              r_tx       <= 1'b0;
            end else begin
              r_tx_state <= StIdle;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        default: r_tx_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // r_rx_s2 is the synchronized line; r_rx_s3 is its previous value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= StIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        StIdle: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_state <= StStart;
            r_rx_cnt   <= w_half_m1;
          end
        end
        StStart: begin
          if (r_rx_cnt == 16'd0) begin
            if (r_rx_s2) begin
              r_rx_state <= StIdle;
            end else begin
              r_rx_state <= StData;
              r_rx_cnt   <= r_baud;
              r_rx_bit   <= '0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        StData: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_baud;
            if (r_rx_bit == 3'd7) r_rx_state <= StStop;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        StStop: begin
          if (r_rx_cnt == 16'd0) r_rx_state <= StIdle;
          else                   r_rx_cnt   <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= StIdle;
      endcase
    end
  end

  assign ack    = r_ack;
  assign dtr    = r_dtr;
  assign tx     = r_tx;
  assign irq_rx = r_irq_rx;
  assign irq_tx = r_irq_tx;

endmodule

// File: tb/tb_dev_uart8.sv
// Self-checking bench for dev_uart8: bus register access, TX line decoding,
// RX frame injection against a queue-based model, interrupts and reset.
module tb_dev_uart8;

  localparam int unsigned DIV = 3;
  localparam int unsigned BIT = DIV + 1;

  logic        clk = 1'b0;
  logic        reset, stb, rw, ack, rx, tx, irq_rx, irq_tx;
  logic [2:0]  addr;
  logic [31:0] dwrite, dtr;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dev_uart8 #(.FIFO_DEPTH(4), .DEFAULT_DIV(103)) dut (
    .clk    (clk),
    .reset  (reset),
    .stb    (stb),
    .ack    (ack),
    .rw     (rw),
    .addr   (addr),
    .dwrite (dwrite),
    .dtr    (dtr),
    .rx     (rx),
    .tx     (tx),
    .irq_rx (irq_rx),
    .irq_tx (irq_tx)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One strobe; returns at the ack cycle with the read data captured.
  task automatic bus(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    stb = 1'b1; rw = wr; addr = a; dwrite = wd;
    @(posedge clk);
    #1;
    stb = 1'b0; rw = 1'b0; dwrite = '0;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_ack addr=%0d got=%b want=1", a, ack);
    end
    rd = dtr;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
  endtask

  task automatic decode_tx(output logic [7:0] b, output int s, output logic ok);
    ok = 1'b0; b = '0; s = 0;
    for (int w = 0; w < 200; w++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      s = cyc;
      repeat (BIT / 2) @(posedge clk);
      #1;
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge clk);
        #1;
        b[i] = tx;
      end
      repeat (BIT) @(posedge clk);
      #1;
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] want [4];
    reset = 1'b1; stb = 1'b0; rw = 1'b0; addr = '0; dwrite = '0; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (ack !== 1'b0 || dtr !== 32'd0 || tx !== 1'b1 || irq_rx !== 1'b0 || irq_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b dtr=%h tx=%b irq_rx=%b irq_tx=%b want 0,0,1,0,0",
               ack, dtr, tx, irq_rx, irq_tx);
    end
    want[0] = 32'd0; want[1] = 32'h4; want[2] = 32'd103; want[3] = 32'd0;
    for (int a = 3; a >= 0; a--) begin
      bus(1'b0, 3'(a), 32'd0, rd);
      n_checks++;
      if (rd !== want[a]) begin
        n_fail++;
        $display("FAIL reset_reg addr=%0d got=%h want=%h", a, rd, want[a]);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 1'b0 || dtr !== 32'd0) begin
      n_fail++;
      $display("FAIL ack_one_cycle got ack=%b dtr=%h want 0,0", ack, dtr);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd, r;
    r = $urandom;
    bus(1'b1, 3'd2, {r[15:0], 16'(DIV)}, rd);
    bus(1'b0, 3'd2, 32'd0, rd);
    n_checks++;
    if (rd !== 32'(DIV)) begin
      n_fail++;
      $display("FAIL baud_rw got=%h want=%h", rd, 32'(DIV));
    end
    bus(1'b1, 3'd3, {r[31:2], 2'b10}, rd);
    bus(1'b0, 3'd3, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd2) begin
      n_fail++;
      $display("FAIL ctrl_rw got=%h want=2", rd);
    end
    bus(1'b1, 3'd3, 32'd0, rd);
    bus(1'b1, 3'd6, 32'hFFFF_FFFF, rd);
    bus(1'b0, 3'd2, 32'd0, rd);
    n_checks++;
    if (rd !== 32'(DIV)) begin
      n_fail++;
      $display("FAIL unmapped_write got baud=%h want=%h", rd, 32'(DIV));
    end
    for (int a = 4; a < 8; a++) begin
      bus(1'b0, 3'(a), 32'd0, rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++;
        $display("FAIL unmapped_read addr=%0d got=%h want=0", a, rd);
      end
    end
  endtask

  task automatic test_tx_single(input logic [7:0] b);
    logic [31:0] rd;
    logic [9:0]  f;
    f = {1'b1, b, 1'b0};
    bus(1'b1, 3'd0, {24'd0, b}, rd);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_latency got=%b want=1 one cycle after write", tx);
    end
    for (int i = 0; i < 10 * BIT; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (tx !== f[i / BIT]) begin
        n_fail++;
        $display("FAIL tx_line byte=%h clk=%0d got=%b want=%b", b, i, tx, f[i / BIT]);
      end
    end
    repeat (2) @(posedge clk);
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL tx_done_status got=%h want=4", rd);
    end
  endtask

  task automatic test_tx_burst();
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          starts [$];
    logic [7:0]  bytes [6];
    logic [31:0] rd, rd2, st_want;
    logic [7:0]  db;
    int          ds, occ;
    logic        dok;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    occ = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          // the first byte leaves the FIFO as its frame begins, concurrent with the next write
          if (i == 1) occ--;
          bus(1'b1, 3'd0, {24'd0, bytes[i]}, rd);
          if (occ < 4) begin
            exp_q.push_back(bytes[i]);
            occ++;
          end
        end
        bus(1'b0, 3'd1, 32'd0, rd2);
        st_want = 32'h8 | ((occ == 4) ? 32'h2 : 32'h0);
        n_checks++;
        if (rd2 !== st_want) begin
          n_fail++;
          $display("FAIL burst_status got=%h want=%h", rd2, st_want);
        end
      end
      begin
        for (int f = 0; f < 6; f++) begin
          decode_tx(db, ds, dok);
          if (!dok) break;
          got_q.push_back(db);
          starts.push_back(ds);
        end
      end
    join
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL burst_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int f = 0; f < got_q.size() && f < exp_q.size(); f++) begin
      n_checks++;
      if (got_q[f] !== exp_q[f]) begin
        n_fail++;
        $display("FAIL burst_byte idx=%0d got=%h want=%h", f, got_q[f], exp_q[f]);
      end
      if (f > 0) begin
        n_checks++;
        if (starts[f] - starts[f-1] != 10 * BIT) begin
          n_fail++;
          $display("FAIL burst_gap idx=%0d got=%0d want=%0d", f, starts[f] - starts[f-1], 10 * BIT);
        end
      end
    end
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL burst_end_status got=%h want=4", rd);
    end
  endtask

  task automatic test_rx_single(input logic [7:0] b);
    logic [31:0] rd;
    send_rx(b, 1'b1);
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h5) begin
      n_fail++;
      $display("FAIL rx_status_valid got=%h want=5", rd);
    end
    bus(1'b0, 3'd0, 32'd0, rd);
    n_checks++;
    if (rd !== {24'd0, b}) begin
      n_fail++;
      $display("FAIL rx_data got=%h want=%h", rd, {24'd0, b});
    end
    bus(1'b0, 3'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL rx_empty_read got=%h want=0", rd);
    end
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL rx_status_drained got=%h want=4", rd);
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0]  q [$];
    logic [7:0]  b, want_b;
    logic        ovr;
    logic [31:0] rd, st_want;
    ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      if (q.size() < 4) q.push_back(b);
      else ovr = 1'b1;
    end
    st_want = 32'h4 | (ovr ? 32'h10 : 32'h0) | ((q.size() > 0) ? 32'h1 : 32'h0);
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== st_want) begin
      n_fail++;
      $display("FAIL overrun_status got=%h want=%h", rd, st_want);
    end
    st_want = st_want & ~32'h30;
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== st_want) begin
      n_fail++;
      $display("FAIL overrun_cleared got=%h want=%h", rd, st_want);
    end
    while (q.size() > 0) begin
      want_b = q.pop_front();
      bus(1'b0, 3'd0, 32'd0, rd);
      n_checks++;
      if (rd !== {24'd0, want_b}) begin
        n_fail++;
        $display("FAIL overrun_order got=%h want=%h", rd, {24'd0, want_b});
      end
    end
    bus(1'b0, 3'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL overrun_drained got=%h want=0", rd);
    end
  endtask

  task automatic test_rx_errors();
    logic [31:0] rd;
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL glitch_status got=%h want=4", rd);
    end
    send_rx(8'($urandom), 1'b0);
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h24) begin
      n_fail++;
      $display("FAIL frame_err_status got=%h want=24", rd);
    end
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL frame_err_cleared got=%h want=4", rd);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic [7:0]  b;
    b = 8'($urandom);
    bus(1'b1, 3'd3, 32'd3, rd);
    @(posedge clk);
    #1;
    n_checks++;
    if (irq_tx !== 1'b1 || irq_rx !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle got tx=%b rx=%b want 1,0", irq_tx, irq_rx);
    end
    send_rx(b, 1'b1);
    n_checks++;
    if (irq_rx !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx_set got=%b want=1", irq_rx);
    end
    bus(1'b0, 3'd0, 32'd0, rd);
    n_checks++;
    if (rd !== {24'd0, b} || irq_rx !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_read got data=%h irq_rx=%b want %h,1", rd, irq_rx, b);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (irq_rx !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_rx_clear got=%b want=0", irq_rx);
    end
    bus(1'b1, 3'd3, 32'd0, rd);
    @(posedge clk);
    #1;
    n_checks++;
    if (irq_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_tx_disable got=%b want=0", irq_tx);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] rd;
    int          lows;
    bus(1'b1, 3'd0, 32'($urandom_range(0, 255)), rd);
    bus(1'b1, 3'd0, 32'($urandom_range(0, 255)), rd);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx_idle got=%b want=1", tx);
    end
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL reset_line_quiet got=%0d low cycles want=0", lows);
    end
    bus(1'b0, 3'd1, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_fifo_empty got=%h want=4", rd);
    end
    bus(1'b0, 3'd2, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd103) begin
      n_fail++;
      $display("FAIL reset_baud got=%0d want=103", rd);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_single(8'hA5);
    test_tx_single(8'($urandom));
    test_tx_burst();
    test_rx_single(8'h3C);
    test_rx_single(8'($urandom));
    test_rx_overrun();
    test_rx_errors();
    test_irq();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
